type_accum_bank: RTL and testbench

TYPE_ACCUM_BANK -- requirements
Module: type_accum_bank

---
 rtl/type_accum_bank.sv | 129 ++++++++++++
 tb/tb_type_accum_bank.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/type_accum_bank.sv
// Bank of independent accumulators driven by a valid/ready command stream.
// Each accepted command produces one registered result; overflow can wrap or saturate.
module type_accum_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             d,
  output logic             q,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_ch,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_ch,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [64:0]      xact_count
);
  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  logic [WIDTH-1:0] acc_reg [CHANNELS];
  logic             q_reg;
  logic             out_valid_reg;
  logic [CW-1:0]    out_ch_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_ovf_reg;
  logic [64:0]      xact_count_reg;

  logic             accept;
  logic             in_range;
  logic [WIDTH-1:0] cur_acc;
  logic [WIDTH-1:0] smin;
  logic [WIDTH-1:0] smax;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign in_range = {1'b0, in_ch} < (CW + 1)'(CHANNELS);
  assign cur_acc  = in_range ? acc_reg[in_ch] : '0;

  always_comb begin
    smin           = '0;
    smin[WIDTH-1]  = 1'b1;
    smax           = ~smin;
    a_ext          = (SIGNED != 0) ? {cur_acc[WIDTH-1], cur_acc} : {1'b0, cur_acc};
    b_ext          = (SIGNED != 0) ? {in_data[WIDTH-1], in_data} : {1'b0, in_data};
    raw            = '0;
    ovf_next       = 1'b0;
    case (op_e'(in_op))
      OP_LOAD:  raw = b_ext;
      OP_ADD:   raw = a_ext + b_ext;
      OP_SUB:   raw = a_ext - b_ext;
      default:  raw = '0;
    endcase
    // One guard bit: unsigned carry/borrow lands in raw[WIDTH]; signed overflow
    // shows as the guard bit disagreeing with the result sign.
    if (in_op == OP_ADD || in_op == OP_SUB) begin
      ovf_next = (SIGNED != 0) ? (raw[WIDTH] != raw[WIDTH-1]) : raw[WIDTH];
    end
    res_next = raw[WIDTH-1:0];
    if (ovf_next && SATURATE != 0) begin
      if (SIGNED != 0) begin
        res_next = raw[WIDTH] ? smin : smax;
      end else begin
        res_next = (in_op == OP_ADD) ? '1 : '0;
      end
    end
    if (!in_range) begin
      res_next = '0;
      ovf_next = 1'b1;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_acc
    always_ff @(posedge clk) begin
      if (!rstn) begin
        acc_reg[gi] <= '0;
      end else if (accept && in_range && in_ch == CW'(gi)) begin
        acc_reg[gi] <= res_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_reg          <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_ch_reg     <= '0;
      out_data_reg   <= '0;
      out_ovf_reg    <= 1'b0;
      xact_count_reg <= '0;
    end else begin
      q_reg <= d;
      if (accept) begin
        out_valid_reg  <= 1'b1;
        out_ch_reg     <= in_ch;
        out_data_reg   <= res_next;
        out_ovf_reg    <= ovf_next;
        xact_count_reg <= xact_count_reg + 65'd1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign q          = q_reg;
  assign out_valid  = out_valid_reg;
  assign out_ch     = out_ch_reg;
  assign out_data   = out_data_reg;
  assign out_ovf    = out_ovf_reg;
  assign xact_count = xact_count_reg;

endmodule

// File: tb/tb_type_accum_bank.sv
// Four accumulator banks (all SIGNED/SATURATE combinations) share one command
// stream and are checked every cycle against an integer-arithmetic model.
module tb_type_accum_bank;
  localparam int W  = 8;
  localparam int CH = 3;
  localparam int N  = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       d = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [1:0] in_ch = '0;
  logic [1:0] in_op = '0;
  logic [7:0] in_data = '0;

  logic        q_o         [N];
  logic        in_ready_o  [N];
  logic        out_valid_o [N];
  logic        out_ovf_o   [N];
  logic [1:0]  out_ch_o    [N];
  logic [7:0]  out_data_o  [N];
  logic [64:0] xc_o        [N];

  always #5 clk = ~clk;

  // Instance k: SIGNED = k%2, SATURATE = k/2
  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    type_accum_bank #(
      .WIDTH(W), .CHANNELS(CH), .SIGNED(gi % 2), .SATURATE(gi / 2)
    ) u_dut (
      .clk(clk), .rstn(rstn), .d(d), .q(q_o[gi]),
      .in_valid(in_valid), .in_ready(in_ready_o[gi]), .in_ch(in_ch),
      .in_op(in_op), .in_data(in_data), .out_valid(out_valid_o[gi]),
      .out_ready(out_ready), .out_ch(out_ch_o[gi]), .out_data(out_data_o[gi]),
      .out_ovf(out_ovf_o[gi]), .xact_count(xc_o[gi])
    );
  end

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [7:0]  macc [N][CH];
  logic        m_valid = 1'b0;
  logic        m_q = 1'b0;
  logic [1:0]  m_ch = '0;
  logic [7:0]  m_data [N];
  logic        m_ovf  [N];
  logic [64:0] m_count = '0;

  function automatic void model_op(input int s, input int sat, input logic [7:0] a,
                                   input logic [1:0] op, input logic [7:0] b,
                                   output logic [7:0] r, output logic o);
    int av, bv, rv, lo, hi;
    av = s ? int'($signed(a)) : int'(a);
    bv = s ? int'($signed(b)) : int'(b);
    lo = s ? -128 : 0;
    hi = s ? 127 : 255;
    o  = 1'b0;
    case (op)
      2'd0:    rv = bv;
      2'd1:    rv = av + bv;
      2'd2:    rv = av - bv;
      default: rv = 0;
    endcase
    if ((op == 2'd1 || op == 2'd2) && (rv < lo || rv > hi)) begin
      o = 1'b1;
      if (sat) rv = (rv < lo) ? lo : hi;
    end
    r = rv[7:0];
  endfunction

  always @(posedge clk) begin
    logic [7:0] r;
    logic o;
    if (!rstn) begin
      m_valid = 1'b0; m_q = 1'b0; m_ch = '0; m_count = '0;
      for (int k = 0; k < N; k++) begin
        m_data[k] = '0; m_ovf[k] = 1'b0;
        for (int c = 0; c < CH; c++) macc[k][c] = '0;
      end
    end else begin
      m_q = d;
      if (in_valid && (!m_valid || out_ready)) begin
        m_count++;
        m_valid = 1'b1;
        m_ch = in_ch;
        for (int k = 0; k < N; k++) begin
          if (int'(in_ch) < CH) begin
            model_op(k % 2, k / 2, macc[k][in_ch], in_op, in_data, r, o);
            macc[k][in_ch] = r;
            m_data[k] = r; m_ovf[k] = o;
          end else begin
            m_data[k] = '0; m_ovf[k] = 1'b1;
          end
        end
        $display("xact ch=%0d op=%0d data=%02h -> uw=%02h/%0b sw=%02h/%0b us=%02h/%0b ss=%02h/%0b",
                 in_ch, in_op, in_data, m_data[0], m_ovf[0], m_data[1], m_ovf[1],
                 m_data[2], m_ovf[2], m_data[3], m_ovf[3]);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        chk($sformatf("out_valid[%0d]", k), 65'(out_valid_o[k]), 65'(m_valid));
        chk($sformatf("in_ready[%0d]", k), 65'(in_ready_o[k]), 65'(!m_valid || out_ready));
        chk($sformatf("xact_count[%0d]", k), xc_o[k], m_count);
        chk($sformatf("q[%0d]", k), 65'(q_o[k]), 65'(m_q));
        if (m_valid) begin
          chk($sformatf("out_ch[%0d]", k), 65'(out_ch_o[k]), 65'(m_ch));
          chk($sformatf("out_data[%0d]", k), 65'(out_data_o[k]), 65'(m_data[k]));
          chk($sformatf("out_ovf[%0d]", k), 65'(out_ovf_o[k]), 65'(m_ovf[k]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    d = 1'($urandom);
  endtask

  task automatic cmd(input logic [1:0] ch, input logic [1:0] op, input logic [7:0] data);
    in_valid = 1'b1; in_ch = ch; in_op = op; in_data = data; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic lit(input string name, input int k, input logic [7:0] dat, input logic ovf);
    chk({name, "_data"}, 65'(out_data_o[k]), 65'(dat));
    chk({name, "_ovf"}, 65'(out_ovf_o[k]), 65'(ovf));
  endtask

  initial begin
    logic [7:0] held;
    rstn = 1'b0;
    in_valid = 1'b1;
    step(); step();
    chk_en = 1'b1;
    chk("rst_valid", 65'(out_valid_o[0]), 65'd0);
    chk("rst_ready", 65'(in_ready_o[0]), 65'd1);
    chk("rst_count", xc_o[0], 65'd0);
    in_valid = 1'b0;
    rstn = 1'b1;
    step();

    // unsigned wrap / saturate
    cmd(2'd0, 2'd0, 8'd250);
    cmd(2'd0, 2'd1, 8'd10);
    lit("u_wrap", 0, 8'd4, 1'b1);
    lit("u_sat_hi", 2, 8'd255, 1'b1);
    cmd(2'd0, 2'd2, 8'd255);
    lit("u_sat_sub", 2, 8'd0, 1'b0);
    cmd(2'd0, 2'd2, 8'd1);
    lit("u_sat_lo", 2, 8'd0, 1'b1);

    // signed saturate / wrap
    cmd(2'd1, 2'd0, 8'd127);
    cmd(2'd1, 2'd1, 8'd1);
    lit("s_sat_hi", 3, 8'd127, 1'b1);
    lit("s_wrap_hi", 1, 8'h80, 1'b1);
    cmd(2'd1, 2'd0, 8'h80);
    cmd(2'd1, 2'd2, 8'd1);
    lit("s_sat_lo", 3, 8'h80, 1'b1);
    lit("s_wrap_lo", 1, 8'h7f, 1'b1);

    // backpressure
    out_ready = 1'b1;
    step();
    in_valid = 1'b1; in_ch = 2'd0; in_op = 2'd0; in_data = 8'd7; out_ready = 1'b0;
    step();
    lit("bp_first", 0, 8'd7, 1'b0);
    held = out_data_o[0];
    in_op = 2'd1; in_data = 8'd1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 65'(in_ready_o[0]), 65'd0);
      step();
      chk("bp_hold", 65'(out_data_o[0]), 65'(held));
      chk("bp_valid", 65'(out_valid_o[0]), 65'd1);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_release_valid", 65'(out_valid_o[0]), 65'd1);
    lit("bp_release", 0, 8'd8, 1'b0);

    // channel isolation and reset
    rstn = 1'b0; step(); rstn = 1'b1;
    for (int i = 0; i < 8; i++) cmd((i % 2 == 0) ? 2'd1 : 2'd2, 2'd1, 8'd3);
    lit("iso_ch2", 0, 8'd12, 1'b0);
    chk("iso_count", xc_o[0], 65'd8);
    rstn = 1'b0; step(); rstn = 1'b1;
    chk("rst2_valid", 65'(out_valid_o[0]), 65'd0);
    chk("rst2_data", 65'(out_data_o[0]), 65'd0);
    chk("rst2_count", xc_o[0], 65'd0);
    cmd(2'd1, 2'd1, 8'd1);
    lit("post_rst", 0, 8'd1, 1'b0);

    // out-of-range channel leaves accumulators alone
    cmd(2'd3, 2'd1, 8'd5);
    lit("oor", 2, 8'd0, 1'b1);
    chk("oor_ch", 65'(out_ch_o[2]), 65'd3);
    cmd(2'd1, 2'd1, 8'd0);
    lit("oor_after", 0, 8'd1, 1'b0);

    // counter wrap
    force g_dut[0].u_dut.xact_count_reg = {65{1'b1}};
    force g_dut[1].u_dut.xact_count_reg = {65{1'b1}};
    force g_dut[2].u_dut.xact_count_reg = {65{1'b1}};
    force g_dut[3].u_dut.xact_count_reg = {65{1'b1}};
    release g_dut[0].u_dut.xact_count_reg;
    release g_dut[1].u_dut.xact_count_reg;
    release g_dut[2].u_dut.xact_count_reg;
    release g_dut[3].u_dut.xact_count_reg;
    m_count = {65{1'b1}};
    cmd(2'd0, 2'd3, 8'hff);
    chk("count_wrap", xc_o[0], 65'd0);
    lit("clear", 1, 8'd0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ch     = 2'($urandom_range(0, 3));
      in_op     = 2'($urandom);
      case ($urandom_range(0, 4))
        0:       in_data = 8'h00;
        1:       in_data = 8'hff;
        2:       in_data = 8'h80;
        3:       in_data = 8'h7f;
        default: in_data = 8'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      rstn      = ($urandom_range(0, 99) != 0);
      step();
    end
    in_valid = 1'b0;
    rstn = 1'b1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
